ysyx_24120009_ifu_fetch: RTL and testbench

Instruction fetch unit for the ysyx_24120009 multi-cycle core: it owns the architectural PC, fetches one instruction per retirement over a valid/ready instruction-memory port and presents it to the decode stage with a one-cycle `inst_valid` pulse. It also closes the control-flow loop. It latches the decode stage's `pc_sel` and target feedback when decode completes, then starts the next fetch only after write-back signals retirement.

---
 rtl/ysyx_24120009_ifu_fetch.sv | 146 ++++++++++++++
 tb/tb_ysyx_24120009_ifu_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24120009_ifu_fetch.sv
// ysyx_24120009_ifu_fetch
// Instruction fetch unit for the multi-cycle core. Owns the architectural PC,
// fetches one instruction per retirement over a valid/ready instruction-memory
// port, and presents it to decode with a one-cycle inst_valid pulse. Next-PC
// feedback from decode is latched on id_done_i. The next fetch starts only
// after wb_done_i signals retirement.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_valid/ready     fetch request handshake
//   imem_req_addr            fetch address (the PC register)
//   imem_rsp_valid/data/err  fetch response, err qualified by valid
//   inst_o, pc_o             held instruction and its PC for decode
//   inst_valid               one-cycle pulse, new instruction available
//   id_done_i, pc_sel        decode completion and next-PC select
//   jump_reg_target_i        JALR target
//   br_target_i              branch target
//   jmp_target_i             JAL target
//   wb_done_i                instruction retired
//   ifu_err_o                sticky fault flag
//   ifu_state_debug          current state encoding
module ysyx_24120009_ifu_fetch #(
   parameter int unsigned                DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]      RESET_PC   = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [31:0]           imem_rsp_data,
   input  logic                  imem_rsp_err,
   output logic [31:0]           inst_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  inst_valid,
   input  logic                  id_done_i,
   input  logic [2:0]            pc_sel,
   input  logic [DATA_WIDTH-1:0] jump_reg_target_i,
   input  logic [DATA_WIDTH-1:0] br_target_i,
   input  logic [DATA_WIDTH-1:0] jmp_target_i,
   input  logic                  wb_done_i,
   output logic                  ifu_err_o,
   output logic [2:0]            ifu_state_debug
);

   localparam logic [31:0] NopInst = 32'h0000_0013;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StReq   = 3'd1,
      StWait  = 3'd2,
      StIssue = 3'd3,
      StDec   = 3'd4,
      StRet   = 3'd5,
      StHalt  = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
   logic [31:0]           inst_q, inst_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] next_pc;

   // Next-PC select; reserved codes fall back to sequential.
   always_comb begin
      next_pc = pc_out_q + DATA_WIDTH'(4);
      case (pc_sel)
         3'b001:  next_pc = {jump_reg_target_i[DATA_WIDTH-1:1], 1'b0};
         3'b010:  next_pc = br_target_i;
         3'b011:  next_pc = jmp_target_i;
         default: next_pc = pc_out_q + DATA_WIDTH'(4);
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      inst_d   = inst_q;
      err_d    = err_q;
      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            if (imem_req_ready) state_d = StWait;
         end
         StWait: begin
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  err_d   = 1'b1;
                  state_d = StHalt;
               end else begin
                  inst_d   = imem_rsp_data;
                  pc_out_d = pc_q;
                  state_d  = StIssue;
               end
            end
         end
         StIssue: state_d = StDec;
         StDec: begin
            if (id_done_i) begin
               if (next_pc[1]) begin
                  // Misaligned target: fault without committing the PC.
                  err_d   = 1'b1;
                  state_d = StHalt;
               end else begin
                  pc_d    = next_pc;
                  // Retirement in the same cycle skips the RET wait.
                  state_d = wb_done_i ? StReq : StRet;
               end
            end
         end
         StRet: begin
            if (wb_done_i) state_d = StReq;
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         pc_q     <= RESET_PC;
         pc_out_q <= RESET_PC;
         inst_q   <= NopInst;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         inst_q   <= inst_d;
         err_q    <= err_d;
      end
   end

   assign imem_req_valid  = (state_q == StReq);
   assign inst_valid      = (state_q == StIssue);
   assign imem_req_addr   = pc_q;
   assign inst_o          = inst_q;
   assign pc_o            = pc_out_q;
   assign ifu_err_o       = err_q;
   assign ifu_state_debug = state_q;

endmodule

// File: tb/tb_ysyx_24120009_ifu_fetch.sv
// Testbench for ysyx_24120009_ifu_fetch: directed stimulus, a transaction-level
// reference model compared on every cycle, and literal spot checks.
module tb_ysyx_24120009_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        imem_rsp_err = 1'b0;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        inst_valid;
   logic        id_done_i = 1'b0;
   logic [2:0]  pc_sel = 3'b000;
   logic [31:0] jump_reg_target_i = 32'h0;
   logic [31:0] br_target_i = 32'h0;
   logic [31:0] jmp_target_i = 32'h0;
   logic        wb_done_i = 1'b0;
   logic        ifu_err_o;
   logic [2:0]  ifu_state_debug;

   int n_checks = 0;
   int n_fail   = 0;

   ysyx_24120009_ifu_fetch #(
      .DATA_WIDTH(32),
      .RESET_PC  (32'h8000_0000)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_addr    (imem_req_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .imem_rsp_err     (imem_rsp_err),
      .inst_o           (inst_o),
      .pc_o             (pc_o),
      .inst_valid       (inst_valid),
      .id_done_i        (id_done_i),
      .pc_sel           (pc_sel),
      .jump_reg_target_i(jump_reg_target_i),
      .br_target_i      (br_target_i),
      .jmp_target_i     (jmp_target_i),
      .wb_done_i        (wb_done_i),
      .ifu_err_o        (ifu_err_o),
      .ifu_state_debug  (ifu_state_debug)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Phase numbers are the architectural state codes seen on ifu_state_debug.
   int          m_phase   = 0;
   logic [31:0] m_pc      = 32'h8000_0000;
   logic [31:0] m_pc_o    = 32'h8000_0000;
   logic [31:0] m_inst    = 32'h0000_0013;
   logic        m_err     = 1'b0;
   bit          m_started = 1'b0;

   function automatic logic [31:0] redirect(input logic [2:0] sel, input logic [31:0] cur);
      if (sel == 3'd1) return jump_reg_target_i - (jump_reg_target_i % 2);
      if (sel == 3'd2) return br_target_i;
      if (sel == 3'd3) return jmp_target_i;
      return cur + 32'd4;
   endfunction

   always @(posedge clk) begin
      logic [31:0] tgt;
      if (rst) begin
         m_phase = 0; m_pc = 32'h8000_0000; m_pc_o = 32'h8000_0000;
         m_inst = 32'h0000_0013; m_err = 1'b0; m_started = 1'b1;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (imem_req_ready) m_phase = 2;
      end else if (m_phase == 2) begin
         if (imem_rsp_valid && imem_rsp_err) begin
            m_err = 1'b1; m_phase = 6;
         end else if (imem_rsp_valid) begin
            m_inst = imem_rsp_data; m_pc_o = m_pc; m_phase = 3;
         end
      end else if (m_phase == 3) begin
         m_phase = 4;
      end else if (m_phase == 4) begin
         if (id_done_i) begin
            tgt = redirect(pc_sel, m_pc_o);
            if ((tgt % 4) >= 2) begin
               m_err = 1'b1; m_phase = 6;
            end else begin
               m_pc = tgt;
               m_phase = wb_done_i ? 1 : 5;
            end
         end
      end else if (m_phase == 5) begin
         if (wb_done_i) m_phase = 1;
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (m_started) begin
         check("state", 32'(ifu_state_debug), 32'(m_phase));
         check("req_valid", 32'(imem_req_valid), 32'(m_phase == 1));
         check("inst_valid", 32'(inst_valid), 32'(m_phase == 3));
         check("err", 32'(ifu_err_o), 32'(m_err));
         check("inst_o", inst_o, m_inst);
         check("pc_o", pc_o, m_pc_o);
         if (m_phase != 6) check("req_addr", imem_req_addr, m_pc);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   // Caller is at a negedge with the DUT in REQ. Ends with the DUT in ISSUE or HALT.
   // Stray responses/decode/retire pulses are thrown in where they must be ignored.
   task automatic fetch(input logic [31:0] data, input logic err, input int rdy_dly,
                        input int rsp_dly);
      for (int i = 0; i < rdy_dly; i++) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = i[0];
         imem_rsp_data  = 32'hDEAD_BEEF;
         tick();
      end
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < rsp_dly; i++) begin
         id_done_i = i[0];
         wb_done_i = i[0];
         tick();
      end
      id_done_i = 1'b0;
      wb_done_i = 1'b0;
      if (rsp_dly > 0) begin
         check("no_early_valid", 32'(inst_valid), 32'd0);
         check("still_wait", 32'(ifu_state_debug), 32'd2);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      imem_rsp_err   = err;
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
   endtask

   // Caller is at a negedge with the DUT in ISSUE.
   task automatic decode(input logic [2:0] sel, input logic [31:0] tgt, input logic together,
                         input logic pre_wb);
      tick();
      if (pre_wb) begin
         wb_done_i = 1'b1;
         tick();
         wb_done_i = 1'b0;
         check("wb_alone_in_dec", 32'(ifu_state_debug), 32'd4);
      end
      jump_reg_target_i = (sel == 3'd1) ? tgt : 32'h1111_1110;
      br_target_i       = (sel == 3'd2) ? tgt : 32'h2222_2220;
      jmp_target_i      = (sel == 3'd3) ? tgt : 32'h3333_3330;
      pc_sel            = sel;
      id_done_i         = 1'b1;
      wb_done_i         = together;
      tick();
      id_done_i = 1'b0;
      wb_done_i = 1'b0;
      pc_sel    = 3'b000;
      if (!together) begin
         tick();
         wb_done_i = 1'b1;
         tick();
         wb_done_i = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      check("rst_state", 32'(ifu_state_debug), 32'd0);
      check("rst_err", 32'(ifu_err_o), 32'd0);
      check("rst_inst", inst_o, 32'h0000_0013);
      check("rst_pc_o", pc_o, 32'h8000_0000);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      rst = 1'b0;
      tick();
      check("restart_req", 32'(imem_req_valid), 32'd1);
      check("restart_addr", imem_req_addr, 32'h8000_0000);
   endtask

   initial begin
      tick();
      tick();
      check("init_inst_valid", 32'(inst_valid), 32'd0);
      do_reset();

      // Best-case latency: REQ at cycle 1, WAIT at 2, ISSUE at 3.
      fetch(32'h0000_0093, 1'b0, 0, 0);
      check("first_valid", 32'(inst_valid), 32'd1);
      check("first_inst", inst_o, 32'h0000_0093);
      check("first_pc", pc_o, 32'h8000_0000);
      decode(3'b000, 32'h0, 1'b0, 1'b1);
      check("seq_addr", imem_req_addr, 32'h8000_0004);

      fetch(32'h0000_0067, 1'b0, 0, 0);
      decode(3'b001, 32'h8000_0101, 1'b0, 1'b0);
      check("jalr_addr", imem_req_addr, 32'h8000_0100);

      fetch(32'h0000_0063, 1'b0, 0, 1);
      decode(3'b010, 32'h8000_0040, 1'b0, 1'b0);
      check("br_addr", imem_req_addr, 32'h8000_0040);

      fetch(32'h0000_006F, 1'b0, 1, 0);
      decode(3'b011, 32'h8000_1000, 1'b1, 1'b0);
      check("together_state", 32'(ifu_state_debug), 32'd1);
      check("jal_addr", imem_req_addr, 32'h8000_1000);

      fetch(32'h0000_0033, 1'b0, 0, 0);
      decode(3'b101, 32'h0, 1'b0, 1'b0);
      check("reserved_addr", imem_req_addr, 32'h8000_1004);

      // Backpressure on both request and response.
      fetch(32'h0000_0013, 1'b0, 5, 7);
      check("bp_pc", pc_o, 32'h8000_1004);
      decode(3'b011, 32'hFFFF_FFFC, 1'b0, 1'b0);
      fetch(32'h0000_0013, 1'b0, 0, 0);
      check("top_pc", pc_o, 32'hFFFF_FFFC);
      decode(3'b000, 32'h0, 1'b0, 1'b0);
      check("wrap_addr", imem_req_addr, 32'h0000_0000);

      // Bus error.
      fetch(32'hDEAD_0000, 1'b1, 0, 0);
      check("rsp_err_state", 32'(ifu_state_debug), 32'd6);
      check("rsp_err_flag", 32'(ifu_err_o), 32'd1);
      check("rsp_err_inst", inst_o, 32'h0000_0013);
      repeat (3) tick();
      check("halt_no_req", 32'(imem_req_valid), 32'd0);
      do_reset();

      // Misaligned branch target.
      fetch(32'h0000_0063, 1'b0, 0, 0);
      decode(3'b010, 32'h8000_0042, 1'b0, 1'b0);
      check("mis_state", 32'(ifu_state_debug), 32'd6);
      check("mis_flag", 32'(ifu_err_o), 32'd1);
      do_reset();

      // Reset while waiting, stale response afterwards.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      check("in_wait", 32'(ifu_state_debug), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_0BAD;
      tick();
      imem_rsp_valid = 1'b0;
      check("stale_inst", inst_o, 32'h0000_0013);
      check("stale_state", 32'(ifu_state_debug), 32'd1);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

endmodule
